workers_debug_mem_arbiter: RTL and testbench
============================================

WORKERS_DEBUG_MEM_ARBITER -- requirements
Module: workers_debug_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, the debug memory slave word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of slave waitrequest cycles before a transfer is aborted (range 1..1023).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports r0_address / r1_address, input, ADDR_W bits each: requester word address.
REQ-006 SHALL have ports r0_read, r0_write / r1_read, r1_write, input, 1 bit each: request strobes, held until waitrequest drops.
REQ-007 SHALL have ports r0_writedata / r1_writedata, input, 32 bits each, and r0_byteenable / r1_byteenable, input, 4 bits each.
REQ-008 SHALL have ports r0_readdata / r1_readdata, output, 32 bits each, and r0_waitrequest / r1_waitrequest, output, 1 bit each.
REQ-009 SHALL have ports s_address (ADDR_W bits), s_read, s_write, s_debugaccess (1 bit each), s_writedata (32 bits) and s_byteenable (4 bits), all outputs, driving the CPU debug memory slave.
REQ-010 SHALL have ports s_readdata, input, 32 bits, and s_waitrequest, input, 1 bit, from the slave.
REQ-011 SHALL have port timeout_err, output, 1 bit: sticky abort flag.
REQ-012 SHALL have port clr_err, input, 1 bit: clears timeout_err.
REQ-013 SHALL have port last_grant, output, 1 bit: the requester that was served last.

Function
REQ-014 SHALL implement FSM states IDLE, XFER and RESP.
REQ-015 In IDLE, a request on exactly one requester SHALL grant that requester.
REQ-016 In IDLE, simultaneous requests SHALL grant the requester that is not last_grant (round-robin).
REQ-017 On a grant, the arbiter SHALL register address, writedata, byteenable, read/write and the grant index, then go to XFER on the next cycle.
REQ-018 A request asserting read and write together SHALL be treated as a write.
REQ-019 In XFER, s_read or s_write SHALL be asserted with the registered fields, and s_debugaccess SHALL be 1.
REQ-020 Outside XFER, s_read, s_write and s_debugaccess SHALL be 0.
REQ-021 XFER SHALL end in the first cycle s_waitrequest is 0; s_readdata SHALL be captured into the granted requester's readdata register, and the FSM SHALL go to RESP.
REQ-022 In XFER, a 10-bit wait counter SHALL increment each cycle s_waitrequest is 1.
REQ-023 When the wait counter reaches TIMEOUT, the arbiter SHALL deassert the slave strobes, load readdata with 32'hDEADBEEF, set timeout_err and go to RESP.
REQ-024 In RESP, the granted requester's waitrequest SHALL be 0 for exactly one cycle; last_grant SHALL update to the grant index, and the FSM SHALL return to IDLE.
REQ-025 A requester's waitrequest SHALL be 1 whenever its read or write is asserted, except in its RESP cycle.
REQ-026 Minimum latency SHALL be 3 cycles from request to waitrequest low (grant, XFER with s_waitrequest=0, RESP).
REQ-027 A requester held continuously SHALL be re-arbitrated in IDLE after RESP, so two continuous requesters alternate.
REQ-028 Each rN_readdata SHALL hold its value until that requester's next completed read.
REQ-029 A requester deasserting its request mid-transfer SHALL NOT abort the transfer; the response is discarded.
REQ-030 clr_err SHALL clear timeout_err; if clr_err and a new timeout occur in the same cycle, timeout_err SHALL be 1.

Reset
REQ-031 Reset SHALL force the FSM to IDLE and clear the wait counter, last_grant, timeout_err, all slave strobes and both readdata registers to 0; r0_waitrequest and r1_waitrequest SHALL then follow REQ-025.
REQ-032 Reset asserted during XFER SHALL drop the slave strobes on the next edge, and no response SHALL be delivered.

Verification
REQ-033 Read: r0 reads address 0x010; the slave returns 0x12345678 after 2 wait cycles -> r0_readdata=0x12345678, r0_waitrequest low 5 cycles after the request, s_debugaccess=1 throughout XFER.
REQ-034 Contention: r0 and r1 both write from reset (last_grant=0) -> r1 is served first, then r0; the s_writedata sequence is r1's data, then r0's; last_grant ends at 0.
REQ-035 Timeout: TIMEOUT=4 and s_waitrequest is stuck at 1 -> strobes drop after 4 wait cycles, readdata=0xDEADBEEF, timeout_err=1 until clr_err is pulsed.
REQ-036 Read+write: r1 asserts read and write together with byteenable=0x3 -> s_write=1, s_read=0, s_byteenable=0x3.
REQ-037 Reset mid-XFER: reset is asserted in the 2nd wait cycle -> next cycle s_read=0, FSM in IDLE, r0_readdata=0.
REQ-038 Continuous: both requesters read continuously for 8 transfers -> grants alternate strictly, and no cycle has more than one requester's waitrequest low.

Source files
------------

// File: rtl/workers_debug_mem_arbiter.sv
// Two-requester round-robin arbiter in front of the CPU debug memory slave.
// One transfer in flight at a time; a stalled slave is aborted after TIMEOUT wait cycles.
module workers_debug_mem_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [31:0]       r0_writedata,
  input  logic [3:0]        r0_byteenable,
  output logic [31:0]       r0_readdata,
  output logic              r0_waitrequest,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [31:0]       r1_writedata,
  input  logic [3:0]        r1_byteenable,
  output logic [31:0]       r1_readdata,
  output logic              r1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic              s_debugaccess,
  output logic [31:0]       s_writedata,
  output logic [3:0]        s_byteenable,
  input  logic [31:0]       s_readdata,
  input  logic              s_waitrequest,
  output logic              timeout_err,
  input  logic              clr_err,
  output logic              last_grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;

  localparam logic [9:0]  WAIT_LAST  = 10'(TIMEOUT - 1);
  localparam logic [31:0] ABORT_WORD = 32'hDEADBEEF;

  state_t            state_reg;
  logic              grant_reg;
  logic              last_grant_reg;
  logic              timeout_err_reg;
  logic              s_read_reg;
  logic              s_write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        be_reg;
  logic [9:0]        wait_cnt_reg;
  logic [31:0]       rdata_reg [2];

  logic [1:0] req;
  logic       pick;
  logic       timeout_hit;

  assign req  = {r1_read | r1_write, r0_read | r0_write};
  // On contention the requester that was not served last wins.
  assign pick = (&req) ? ~last_grant_reg : req[1];
  assign timeout_hit = (state_reg == XFER) && s_waitrequest && (wait_cnt_reg == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_reg       <= 1'b0;
      last_grant_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      s_read_reg      <= 1'b0;
      s_write_reg     <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      be_reg          <= '0;
      wait_cnt_reg    <= '0;
      rdata_reg[0]    <= '0;
      rdata_reg[1]    <= '0;
    end else begin
      // A fresh abort outranks a simultaneous clear.
      if (timeout_hit) begin
        timeout_err_reg <= 1'b1;
      end else if (clr_err) begin
        timeout_err_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_reg    <= pick;
            addr_reg     <= pick ? r1_address    : r0_address;
            wdata_reg    <= pick ? r1_writedata  : r0_writedata;
            be_reg       <= pick ? r1_byteenable : r0_byteenable;
            // read+write together is a write
            s_write_reg  <= pick ? r1_write  : r0_write;
            s_read_reg   <= pick ? ~r1_write : ~r0_write;
            wait_cnt_reg <= '0;
            state_reg    <= XFER;
          end
        end
        XFER: begin
          if (!s_waitrequest) begin
            s_read_reg  <= 1'b0;
            s_write_reg <= 1'b0;
            if (s_read_reg) begin
              rdata_reg[grant_reg] <= s_readdata;
            end
            state_reg <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 10'd1;
            if (timeout_hit) begin
              s_read_reg           <= 1'b0;
              s_write_reg          <= 1'b0;
              rdata_reg[grant_reg] <= ABORT_WORD;
              state_reg            <= RESP;
            end
          end
        end
        RESP: begin
          last_grant_reg <= grant_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s_address     = addr_reg;
  assign s_writedata   = wdata_reg;
  assign s_byteenable  = be_reg;
  assign s_read        = s_read_reg;
  assign s_write       = s_write_reg;
  assign s_debugaccess = s_read_reg | s_write_reg;

  assign r0_readdata    = rdata_reg[0];
  assign r1_readdata    = rdata_reg[1];
  assign r0_waitrequest = req[0] & ~((state_reg == RESP) && !grant_reg);
  assign r1_waitrequest = req[1] & ~((state_reg == RESP) &&  grant_reg);
  assign timeout_err    = timeout_err_reg;
  assign last_grant     = last_grant_reg;

endmodule

// File: tb/tb_workers_debug_mem_arbiter.sv
// Scoreboard bench: requester drivers push expected responses, a negedge monitor pops
// and compares on every handshake; a behavioural slave memory answers the arbiter.
module tb_workers_debug_mem_arbiter;
  localparam int AW = 9;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] r0_address, r1_address, s_address;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [31:0]   r0_writedata, r1_writedata, r0_readdata, r1_readdata;
  logic [3:0]    r0_byteenable, r1_byteenable, s_byteenable;
  logic          r0_waitrequest, r1_waitrequest;
  logic          s_read, s_write, s_debugaccess, s_waitrequest;
  logic [31:0]   s_writedata, s_readdata;
  logic          timeout_err, clr_err, last_grant;

  always #5 clk = ~clk;

  workers_debug_mem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
    .r0_readdata(r0_readdata), .r0_waitrequest(r0_waitrequest),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
    .r1_readdata(r1_readdata), .r1_waitrequest(r1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_debugaccess(s_debugaccess), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest), .timeout_err(timeout_err),
    .clr_err(clr_err), .last_grant(last_grant)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] slv_mem   [512];
  logic [31:0] model_mem [512];
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  logic [31:0] wlog [$];
  logic [5:0]  cmd_log [$];
  int          addr_log [$];
  int          fixed_wait = -1;
  bit          stuck = 1'b0;
  bit          slv_busy = 1'b0;
  int          slv_wait = 0;
  int          strobe_cycles = 0;
  int          dbg_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Behavioural slave: random or fixed wait states, or stuck busy.
  initial begin
    forever begin
      @(negedge clk);
      if (s_debugaccess) dbg_cycles++;
      if (s_read || s_write) begin
        if (!slv_busy) begin
          slv_busy = 1'b1;
          slv_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
          cmd_log.push_back({s_read, s_write, s_byteenable});
          addr_log.push_back(int'(s_address));
        end
        strobe_cycles++;
        if (stuck || slv_wait > 0) begin
          s_waitrequest = 1'b1;
          if (slv_wait > 0) slv_wait--;
        end else begin
          s_waitrequest = 1'b0;
          if (s_write) begin
            slv_mem[s_address] = merge(slv_mem[s_address], s_writedata, s_byteenable);
            wlog.push_back(s_writedata);
          end else begin
            s_readdata = slv_mem[s_address];
          end
          slv_busy = 1'b0;
        end
      end else begin
        slv_busy      = 1'b0;
        s_waitrequest = 1'b1;
        s_readdata    = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on every requester handshake.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if ((r0_read || r0_write) && (r1_read || r1_write)) begin
        total++;
        if (!r0_waitrequest && !r1_waitrequest) begin
          bad++;
          $display("FAIL both_wait_low: r0_wait=%b r1_wait=%b required one high", r0_waitrequest, r1_waitrequest);
        end
      end
      if ((r0_read || r0_write) && !r0_waitrequest) begin
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp_r0: got handshake required none");
        end else begin
          e = exp_q0.pop_front();
          if (e[32]) check("r0_readdata", r0_readdata, e[31:0]);
          $display("txn r0 %s rdata=%h", e[32] ? "read " : "write", r0_readdata);
        end
      end
      if ((r1_read || r1_write) && !r1_waitrequest) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp_r1: got handshake required none");
        end else begin
          e = exp_q1.pop_front();
          if (e[32]) check("r1_readdata", r1_readdata, e[31:0]);
          $display("txn r1 %s rdata=%h", e[32] ? "read " : "write", r1_readdata);
        end
      end
    end
  end

  // Issue one request; call just after a rising edge. Returns at rising edge + 1.
  task automatic do_req(input int n, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input bit push,
                        output int lat);
    logic [32:0] e;
    if (push) begin
      if (wr) begin
        model_mem[a] = merge(model_mem[a], wd, be);
        e = {1'b0, 32'h0};
      end else begin
        e = {1'b1, model_mem[a]};
      end
      if (n == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    end
    if (n == 0) begin
      r0_address = a; r0_read = rd; r0_write = wr; r0_writedata = wd; r0_byteenable = be;
    end else begin
      r1_address = a; r1_read = rd; r1_write = wr; r1_writedata = wd; r1_byteenable = be;
    end
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if ((n == 0) ? !r0_waitrequest : !r1_waitrequest) break;
      if (lat > 100) begin
        total++; bad++;
        $display("FAIL handshake_r%0d: got no waitrequest drop in %0d cycles required one", n, lat);
        break;
      end
    end
    @(posedge clk); #1;
    if (n == 0) begin r0_read = 1'b0; r0_write = 1'b0; end
    else begin r1_read = 1'b0; r1_write = 1'b0; end
  endtask

  task automatic rand_drv(input int n, input int cnt);
    int lat;
    int rw;
    for (int i = 0; i < cnt; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      rw = int'($urandom_range(0, 2));
      do_req(n, rw != 1, rw != 0, AW'(int'($urandom_range(0, 15)) * 2 + n),
             $urandom, 4'($urandom), 1'b1, lat);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat0, lat1, k;
    reset = 1'b1; clr_err = 1'b0;
    r0_address = '0; r0_read = 0; r0_write = 0; r0_writedata = 0; r0_byteenable = 0;
    r1_address = '0; r1_read = 0; r1_write = 0; r1_writedata = 0; r1_byteenable = 0;
    s_waitrequest = 1'b1; s_readdata = '0;
    for (int a = 0; a < 512; a++) begin
      slv_mem[a]   = (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
      model_mem[a] = slv_mem[a];
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_s_read", s_read, 0);
    check("rst_s_write", s_write, 0);
    check("rst_debugaccess", s_debugaccess, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_last_grant", last_grant, 0);
    check("rst_r0_readdata", r0_readdata, 0);
    check("rst_r1_readdata", r1_readdata, 0);
    check("rst_r0_wait_idle", r0_waitrequest, 0);

    // Basic read with two slave wait cycles.
    slv_mem[16] = 32'h12345678; model_mem[16] = 32'h12345678;
    fixed_wait = 2; strobe_cycles = 0; dbg_cycles = 0;
    @(posedge clk); #1;
    do_req(0, 1, 0, 9'h010, 32'h0, 4'hF, 1'b1, lat);
    check("read_latency", 32'(lat), 5);
    check("read_xfer_cycles", 32'(strobe_cycles), 3);
    check("read_debug_cycles", 32'(dbg_cycles), 3);
    check("read_data_held", r0_readdata, 32'h12345678);

    // Contention straight after reset: r1 first, then r0.
    reset_pulse();
    fixed_wait = 0; wlog.delete();
    fork
      do_req(0, 0, 1, 9'h040, 32'hAAAA0000, 4'hF, 1'b1, lat0);
      do_req(1, 0, 1, 9'h041, 32'hBBBB1111, 4'hF, 1'b1, lat1);
    join
    @(negedge clk);
    check("contend_writes", 32'(wlog.size()), 2);
    if (wlog.size() >= 2) begin
      check("contend_first", wlog[0], 32'hBBBB1111);
      check("contend_second", wlog[1], 32'hAAAA0000);
    end
    check("contend_last_grant", last_grant, 0);

    // Read and write together is a write; minimum latency.
    cmd_log.delete();
    @(posedge clk); #1;
    do_req(1, 1, 1, 9'h043, 32'hCAFEF00D, 4'h3, 1'b1, lat);
    check("rw_latency", 32'(lat), 3);
    if (cmd_log.size() >= 1) check("rw_cmd", 32'(cmd_log[0]), 32'({1'b0, 1'b1, 4'h3}));
    else check("rw_cmd_seen", 32'(cmd_log.size()), 1);
    do_req(1, 1, 0, 9'h043, 32'h0, 4'hF, 1'b1, lat);

    // Timeout with the slave stuck busy.
    stuck = 1'b1; strobe_cycles = 0;
    exp_q0.push_back({1'b1, 32'hDEADBEEF});
    do_req(0, 1, 0, 9'h030, 32'h0, 4'hF, 1'b0, lat);
    check("to_xfer_cycles", 32'(strobe_cycles), TO);
    check("to_latency", 32'(lat), TO + 2);
    @(negedge clk);
    check("to_err_set", timeout_err, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("to_err_sticky", timeout_err, 1);
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("to_err_cleared", timeout_err, 0);

    // clr_err held through the abort edge: the new timeout wins.
    @(posedge clk); #1 clr_err = 1'b1;
    exp_q0.push_back({1'b1, 32'hDEADBEEF});
    fork
      do_req(0, 1, 0, 9'h032, 32'h0, 4'hF, 1'b0, lat);
      begin
        k = 0;
        while (!s_read && k < 50) begin @(negedge clk); k++; end
        while (s_read && k < 50) begin @(negedge clk); k++; end
        clr_err = 1'b0;
        check("to_err_vs_clr", timeout_err, 1);
      end
    join
    @(negedge clk);
    check("to_err_vs_clr_hold", timeout_err, 1);
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;

    // Reset in the second wait cycle of a read.
    r0_address = 9'h020; r0_read = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!s_read && k < 20);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstx_s_read", s_read, 0);
    check("rstx_debugaccess", s_debugaccess, 0);
    check("rstx_r0_readdata", r0_readdata, 0);
    check("rstx_r0_wait", r0_waitrequest, 1);
    @(posedge clk); #1 reset = 1'b0; r0_read = 1'b0; stuck = 1'b0;

    // Continuous readers alternate strictly.
    fixed_wait = -1; addr_log.delete();
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 4; i++) do_req(0, 1, 0, AW'(2 * i), 32'h0, 4'hF, 1'b1, lat0);
      for (int i = 0; i < 4; i++) do_req(1, 1, 0, AW'(2 * i + 1), 32'h0, 4'hF, 1'b1, lat1);
    join
    check("cont_count", 32'(addr_log.size()), 8);
    if (addr_log.size() >= 8) begin
      check("cont_first_r1", 32'(addr_log[0] & 1), 1);
      for (int i = 1; i < 8; i++)
        check("cont_alternate", 32'(addr_log[i] & 1), 32'((addr_log[i-1] & 1) ^ 1));
    end

    // Randomized traffic from both requesters.
    fork
      rand_drv(0, 30);
      rand_drv(1, 30);
    join
    repeat (5) @(posedge clk);
    check("drain_q0", 32'(exp_q0.size()), 0);
    check("drain_q1", 32'(exp_q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
